// File: rtl/regfile_wb_arbiter.sv
// Two-requester (ALU / load unit) write-back arbiter with a registered register-file write port.
// Define WB_SCOREBOARD_EN to add the 32-entry pending-write scoreboard driving busy1/busy2.
module regfile_wb_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_stall,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              lsu_valid,
  input  logic [4:0]        lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  output logic              lsu_ready,
  output logic              reg_write,
  output logic [4:0]        write_reg,
  output logic [DATA_W-1:0] write_data,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic [4:0]        chk_rs1,
  input  logic [4:0]        chk_rs2,
  output logic              busy1,
  output logic              busy2
);

  // r_prio: 0 favours the ALU, 1 favours the load unit when both request.
  logic              r_prio;
  logic              w_xfer;
  logic              w_selLsu;
  logic [4:0]        w_selRd;
  logic [DATA_W-1:0] w_selData;

  always_comb begin
    alu_ready = 1'b0;
    lsu_ready = 1'b0;
    if (rst_n && !wb_stall) begin
      alu_ready = alu_valid && (!lsu_valid || !r_prio);
      lsu_ready = lsu_valid && (!alu_valid || r_prio);
    end
  end

  assign w_xfer    = alu_ready || lsu_ready;
  assign w_selLsu  = lsu_ready;
  assign w_selRd   = w_selLsu ? lsu_rd : alu_rd;
  assign w_selData = w_selLsu ? lsu_data : alu_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prio     <= 1'b0;
      reg_write  <= 1'b0;
      write_reg  <= '0;
      write_data <= '0;
    end else begin
      reg_write <= 1'b0;
      if (w_xfer) begin
        r_prio <= alu_ready;
        // rd==0 requests are consumed but never reach the register file.
        if (w_selRd != 5'd0) begin
          reg_write  <= 1'b1;
          write_reg  <= w_selRd;
          write_data <= w_selData;
        end
      end
    end
  end

`ifdef WB_SCOREBOARD_EN
  logic [31:0] r_pending;
  logic [31:0] w_pendingNext;

  // Clear for the retiring write first so a same-edge issue of that register wins.
  always_comb begin
    w_pendingNext = r_pending;
    if (w_xfer && (w_selRd != 5'd0))
      w_pendingNext[w_selRd] = 1'b0;
    if (issue_valid && (issue_rd != 5'd0))
      w_pendingNext[issue_rd] = 1'b1;
    w_pendingNext[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_pending <= '0;
    else
      r_pending <= w_pendingNext;
  end

  assign busy1 = r_pending[chk_rs1] && (chk_rs1 != 5'd0);
  assign busy2 = r_pending[chk_rs2] && (chk_rs2 != 5'd0);
`else
  logic w_unused_sb;
  assign w_unused_sb = ^{issue_valid, issue_rd, chk_rs1, chk_rs2};
  assign busy1 = 1'b0;
  assign busy2 = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: a vector table for arbitration and write-back,
// then hand sequences for the scoreboard and asynchronous reset.
module tb_regfile_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wb_stall;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        lsu_valid;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;
  logic        lsu_ready;
  logic        reg_write;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  chk_rs1;
  logic [4:0]  chk_rs2;
  logic        busy1;
  logic        busy2;

  regfile_wb_arbiter #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .wb_stall(wb_stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .busy1(busy1), .busy2(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        st;
    logic        eAr;
    logic        eLr;
    logic        eRw;
    logic [4:0]  eWr;
    logic [31:0] eWd;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Requests seen valid but not accepted, which must be presented unchanged next cycle.
  logic        aluHeld = 1'b0;
  logic        lsuHeld = 1'b0;
  logic [37:0] aluSaved;
  logic [37:0] lsuSaved;

  vec_t vecs[21];

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                              logic lv, logic [4:0] lrd, logic [31:0] ld, logic st,
                              logic eAr, logic eLr, logic eRw, logic [4:0] eWr, logic [31:0] eWd);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld; v.st = st;
    v.eAr = eAr; v.eLr = eLr; v.eRw = eRw; v.eWr = eWr; v.eWd = eWd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    wb_stall  = v.st;
    issue_valid = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input vec_t v);
    @(negedge clk);
    chk({tag, ".alu_ready"}, 64'(alu_ready), 64'(v.eAr));
    chk({tag, ".lsu_ready"}, 64'(lsu_ready), 64'(v.eLr));
    chk({tag, ".reg_write"}, 64'(reg_write), 64'(v.eRw));
    chk({tag, ".write_reg"}, 64'(write_reg), 64'(v.eWr));
    chk({tag, ".write_data"}, 64'(write_data), 64'(v.eWd));
    if (aluHeld) chk({tag, ".alu_hold"}, 64'({alu_valid, alu_rd, alu_data}), 64'(aluSaved));
    if (lsuHeld) chk({tag, ".lsu_hold"}, 64'({lsu_valid, lsu_rd, lsu_data}), 64'(lsuSaved));
    aluHeld  = alu_valid && !alu_ready;
    lsuHeld  = lsu_valid && !lsu_ready;
    aluSaved = {alu_valid, alu_rd, alu_data};
    lsuSaved = {lsu_valid, lsu_rd, lsu_data};
  endtask

  initial begin
    rst_n = 1'b0; wb_stall = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0;
    issue_valid = 1'b0; issue_rd = '0; chk_rs1 = '0; chk_rs2 = '0;

    //        av ard  ad            lv lrd ld            st  eAr eLr eRw eWr eWd
    vecs[0]  = mk(1, 3, 32'hAAAA0001, 1, 4, 32'hBBBB0002, 0,  1, 0, 0, 0, 32'h0);
    vecs[1]  = mk(1, 3, 32'hAAAA0001, 1, 4, 32'hBBBB0002, 0,  0, 1, 1, 3, 32'hAAAA0001);
    vecs[2]  = mk(1, 3, 32'hAAAA0001, 0, 0, 32'h0,        0,  1, 0, 1, 4, 32'hBBBB0002);
    vecs[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 0, 1, 3, 32'hAAAA0001);
    vecs[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 0, 0, 3, 32'hAAAA0001);
    vecs[5]  = mk(0, 0, 32'h0,        1, 7, 32'h71,       0,  0, 1, 0, 3, 32'hAAAA0001);
    vecs[6]  = mk(0, 0, 32'h0,        1, 7, 32'h72,       0,  0, 1, 1, 7, 32'h71);
    vecs[7]  = mk(0, 0, 32'h0,        1, 7, 32'h73,       0,  0, 1, 1, 7, 32'h72);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 0, 1, 7, 32'h73);
    vecs[9]  = mk(1, 1, 32'h11,       1, 2, 32'h22,       1,  0, 0, 0, 7, 32'h73);
    vecs[10] = mk(1, 1, 32'h11,       1, 2, 32'h22,       1,  0, 0, 0, 7, 32'h73);
    vecs[11] = mk(1, 1, 32'h11,       1, 2, 32'h22,       1,  0, 0, 0, 7, 32'h73);
    vecs[12] = mk(1, 1, 32'h11,       1, 2, 32'h22,       1,  0, 0, 0, 7, 32'h73);
    vecs[13] = mk(1, 1, 32'h11,       1, 2, 32'h22,       0,  1, 0, 0, 7, 32'h73);
    vecs[14] = mk(0, 0, 32'h0,        1, 2, 32'h22,       0,  0, 1, 1, 1, 32'h11);
    vecs[15] = mk(1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        0,  1, 0, 1, 2, 32'h22);
    vecs[16] = mk(1, 5, 32'h55,       1, 6, 32'h66,       0,  0, 1, 0, 2, 32'h22);
    vecs[17] = mk(1, 5, 32'h55,       1, 6, 32'h67,       0,  1, 0, 1, 6, 32'h66);
    vecs[18] = mk(0, 0, 32'h0,        1, 6, 32'h67,       0,  0, 1, 1, 5, 32'h55);
    vecs[19] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 0, 1, 6, 32'h67);
    vecs[20] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0,  0, 0, 0, 6, 32'h67);

    // Reset state, with requests present to show readies are held off.
    #2;
    alu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    chk("rst.alu_ready", 64'(alu_ready), 64'd0);
    chk("rst.lsu_ready", 64'(lsu_ready), 64'd0);
    chk("rst.reg_write", 64'(reg_write), 64'd0);
    chk("rst.write_reg", 64'(write_reg), 64'd0);
    chk("rst.write_data", 64'(write_data), 64'd0);
    chk("rst.busy1", 64'(busy1), 64'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    #9 rst_n = 1'b1;

    for (int i = 0; i < 21; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i), vecs[i]);
    end

    // Scoreboard: issue, same-edge issue+retire, then plain retire.
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 32'h67));
    issue_valid = 1'b1; issue_rd = 5'd5; chk_rs1 = 5'd5; chk_rs2 = 5'd0;
    checkOutput("sbA", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 32'h67));
    chk("sbA.busy1", 64'(busy1), 64'd0);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 32'h67));
    checkOutput("sbB", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6, 32'h67));
    chk("sbB.busy1", 64'(busy1), 64'(SB));
    chk("sbB.busy2", 64'(busy2), 64'd0);
    applyStimulus(mk(1, 5, 32'h5A, 0, 0, 0, 0, 1, 0, 0, 6, 32'h67));
    issue_valid = 1'b1; issue_rd = 5'd5;
    checkOutput("sbC", mk(1, 5, 32'h5A, 0, 0, 0, 0, 1, 0, 0, 6, 32'h67));
    chk("sbC.busy1", 64'(busy1), 64'(SB));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h5A));
    checkOutput("sbD", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h5A));
    chk("sbD.busy1", 64'(busy1), 64'(SB));
    applyStimulus(mk(1, 5, 32'h5B, 0, 0, 0, 0, 1, 0, 0, 5, 32'h5A));
    checkOutput("sbE", mk(1, 5, 32'h5B, 0, 0, 0, 0, 1, 0, 0, 5, 32'h5A));
    chk("sbE.busy1", 64'(busy1), 64'(SB));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h5B));
    checkOutput("sbF", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 32'h5B));
    chk("sbF.busy1", 64'(busy1), 64'd0);
    chk("sbF.busy2", 64'(busy2), 64'd0);

    // Mid-cycle reset with a write on the port and r9 pending; prio is 1 beforehand.
    applyStimulus(mk(1, 9, 32'h99, 0, 0, 0, 0, 1, 0, 0, 5, 32'h5B));
    issue_valid = 1'b1; issue_rd = 5'd9; chk_rs1 = 5'd9;
    checkOutput("rsA", mk(1, 9, 32'h99, 0, 0, 0, 0, 1, 0, 0, 5, 32'h5B));
    chk("rsA.busy1", 64'(busy1), 64'd0);
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99));
    checkOutput("rsB", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99));
    chk("rsB.busy1", 64'(busy1), 64'(SB));
    #1;
    rst_n = 1'b0; alu_valid = 1'b1; lsu_valid = 1'b1;
    #1;
    chk("rsC.reg_write", 64'(reg_write), 64'd0);
    chk("rsC.write_reg", 64'(write_reg), 64'd0);
    chk("rsC.write_data", 64'(write_data), 64'd0);
    chk("rsC.busy1", 64'(busy1), 64'd0);
    chk("rsC.alu_ready", 64'(alu_ready), 64'd0);
    chk("rsC.lsu_ready", 64'(lsu_ready), 64'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    aluHeld = 1'b0; lsuHeld = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(mk(1, 3, 32'h31, 1, 4, 32'h41, 0, 1, 0, 0, 0, 32'h0));
    checkOutput("rsD", mk(1, 3, 32'h31, 1, 4, 32'h41, 0, 1, 0, 0, 0, 32'h0));
    chk("rsD.busy1", 64'(busy1), 64'd0);
    applyStimulus(mk(0, 0, 0, 1, 4, 32'h41, 0, 0, 1, 1, 3, 32'h31));
    checkOutput("rsE", mk(0, 0, 0, 1, 4, 32'h41, 0, 0, 1, 1, 3, 32'h31));
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h41));
    checkOutput("rsF", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h41));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk, rst_n.
REQ-002 Parameter: DATA_W, default 32, width of write-back data.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 wb_stall  input  1  when high, no grant is issued this cycle.
REQ-006 alu_valid, alu_rd, alu_data  input  1/5/DATA_W  requester 0 (ALU) write-back request.
REQ-007 alu_ready  output  1  requester 0 accepted this cycle.
REQ-008 lsu_valid, lsu_rd, lsu_data  input  1/5/DATA_W  requester 1 (load unit) write-back request.
REQ-009 lsu_ready  output  1  requester 1 accepted this cycle.
REQ-010 reg_write, write_reg, write_data  output  1/5/DATA_W  register-file write port, registered.
REQ-011 issue_valid, issue_rd  input  1/5  instruction issued that will write issue_rd.
REQ-012 chk_rs1, chk_rs2  input  5/5  source registers to check.
REQ-013 busy1, busy2  output  1/1  source register has a pending write.

Function
REQ-014 Transfer SHALL occur on a rising edge where valid and ready are both high; ready SHALL be combinational from valid, wb_stall and priority.
REQ-015 At most one ready SHALL be high per cycle; no ready SHALL be high while wb_stall is high.
REQ-016 Only one valid high and no stall: that requester SHALL be granted regardless of priority.
REQ-017 Both valid and no stall: the requester indicated by the priority bit prio SHALL be granted.
REQ-018 After every transfer, prio SHALL point to the requester not granted; with no transfer, prio SHALL hold.
REQ-019 An accepted request SHALL appear on reg_write/write_reg/write_data exactly one cycle after the accepting edge, with reg_write high for that one cycle only.
REQ-020 An accepted request with rd==0 SHALL be consumed (ready high, prio updated) but SHALL leave reg_write low.
REQ-021 reg_write SHALL be low in every cycle not following an accepted nonzero-rd transfer; write_reg/write_data SHALL hold their last values when reg_write is low.
REQ-022 A requester SHALL hold valid, rd and data stable until accepted; the bench SHALL flag any violation.
REQ-023 Scoreboard: 32 pending bits; issue_valid with issue_rd!=0 SHALL set pending[issue_rd] at the edge.
REQ-024 An accepted transfer with rd!=0 SHALL clear pending[rd] at the accepting edge.
REQ-025 Set and clear of the same register on the same edge: set SHALL win.
REQ-026 busyN SHALL equal pending[chk_rsN] combinationally from registered state; register 0 SHALL never be busy.

Reset
REQ-027 On rst_n low, asynchronously: reg_write=0, write_reg=0, write_data=0, prio=0 (ALU first), and all pending bits=0.
REQ-028 While rst_n is low, alu_ready and lsu_ready SHALL be 0.
REQ-029 A request accepted at the edge before reset assertion SHALL be lost; after release, arbitration SHALL restart from prio=0.

Configuration
REQ-030 Macro WB_SCOREBOARD_EN defined: REQ-023 to REQ-026 SHALL be implemented.
REQ-031 Macro undefined: no pending storage SHALL exist; busy1=busy2=0; issue_* and chk_* SHALL be ignored; the arbiter SHALL be unchanged.

Verification
REQ-032 After reset, both valid (alu_rd=3 data=0xAAAA0001, lsu_rd=4 data=0xBBBB0002) for 2 cycles -> alu_ready cycle 0, lsu_ready cycle 1; reg_write on r3 then r4, one cycle later each.
REQ-033 Only lsu_valid (rd=7) for 3 consecutive requests -> lsu_ready each cycle, three writes to r7, prio=0 afterwards.
REQ-034 Both valid with wb_stall=1 for 4 cycles -> no ready, reg_write=0; first cycle after stall release grants the requester indicated by prio.
REQ-035 alu_valid rd=0 data=0xFFFFFFFF -> alu_ready=1, reg_write stays 0, prio moves to LSU.
REQ-036 (WB_SCOREBOARD_EN) issue rd=5; chk_rs1=5 -> busy1=1 next cycle; accept alu rd=5 on the same edge as issue rd=5 -> busy1 remains 1; later accept rd=5 without issue -> busy1=0; chk_rs2=0 -> busy2=0 always.
REQ-037 rst_n asserted mid-cycle with reg_write=1 and pending[9]=1 -> reg_write, write_reg, write_data, prio and pending[9] go to 0 immediately, before the next clock edge.
